// File: rtl/phase_mon_pkg.sv
// Shared types, defaults and the ring rotate helper for the phase ring monitor.
package phase_mon_pkg;

    localparam int unsigned N_PHASE_DEF  = 9;
    localparam int unsigned LOCK_LEN_DEF = 3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } mon_state_t;

    // Rotate the low n bits of v left by one, bit n-1 wrapping to bit 0 (n <= 31).
    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        logic [31:0] mask;
        mask = (32'd1 << n) - 32'd1;
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_idx_enc.sv
// Combinational one-hot to binary encoder with a one-hot legality flag.
module onehot_idx_enc #(
    parameter int unsigned N     = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx_c,
    output logic             oh_c
);

    logic seen;
    logic multi;

    // OR of set-bit indices is the index whenever exactly one bit is set.
    always_comb begin
        idx_c = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (vec[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
                idx_c = idx_c | IDX_W'(i);
            end
        end
        oh_c = seen & ~multi;
    end

endmodule

// File: rtl/phase_ring_monitor.sv
// Receive-side monitor for the one-hot phase ring: encode, legality/lock tracking, round count.
// Optional saturating error counter enabled by defining PHASE_MON_ERRCNT_EN.
module phase_ring_monitor
    import phase_mon_pkg::*;
#(
    parameter int unsigned N_PHASE  = N_PHASE_DEF,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned ROUND_W  = 8,
    parameter int unsigned LOCK_LEN = LOCK_LEN_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PHASE-1:0] phase_in,
    input  logic               err_clr,
    output logic [IDX_W-1:0]   phase_idx,
    output logic               phase_valid,
    output logic               locked,
    output logic               round_tick,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               err_onehot,
    output logic               err_seq,
    output logic [7:0]         err_cnt
);

    localparam int unsigned RUN_W = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);

    logic [N_PHASE-1:0] s1;
    logic [N_PHASE-1:0] s2;
    logic [1:0]         fill;
    mon_state_t         state;
    mon_state_t         state_n;
    logic [RUN_W-1:0]   lock_run;
    logic [RUN_W-1:0]   lock_run_n;

    logic [IDX_W-1:0]   idx_c;
    logic               oh_c;
    logic               adv_c;
    logic               legal_c;
    logic               fill_done_c;
    logic               set_oh_c;
    logic               set_seq_c;
    logic               tick_c;
    logic               enter_c;

    onehot_idx_enc #(
        .N     (N_PHASE),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec   (s1),
        .idx_c (idx_c),
        .oh_c  (oh_c)
    );

    assign adv_c       = (s1 == N_PHASE'(rotl(32'(s2), N_PHASE)));
    assign legal_c     = oh_c & adv_c;
    assign fill_done_c = (fill == 2'd2);

    // Lock tracking and per-cycle event decode.
    always_comb begin
        state_n    = state;
        lock_run_n = lock_run;
        set_oh_c   = ~oh_c & fill_done_c;
        set_seq_c  = 1'b0;
        tick_c     = 1'b0;
        enter_c    = 1'b0;
        case (state)
            UNLOCKED: begin
                lock_run_n = '0;
                if (legal_c) begin
                    if (LOCK_LEN == 1) begin
                        state_n = LOCKED;
                        enter_c = 1'b1;
                    end else begin
                        state_n    = LOCKING;
                        lock_run_n = RUN_W'(1);
                    end
                end
            end
            LOCKING: begin
                if (legal_c) begin
                    if (lock_run == RUN_W'(LOCK_LEN - 1)) begin
                        state_n    = LOCKED;
                        lock_run_n = '0;
                        enter_c    = 1'b1;
                    end else begin
                        lock_run_n = lock_run + RUN_W'(1);
                    end
                end else begin
                    state_n    = UNLOCKED;
                    lock_run_n = '0;
                end
            end
            LOCKED: begin
                if (!oh_c) begin
                    state_n = UNLOCKED;
                end else if (!adv_c) begin
                    set_seq_c = 1'b1;
                    state_n   = UNLOCKED;
                end else begin
                    tick_c = s2[N_PHASE-1] & s1[0];
                end
            end
            default: begin
                state_n    = UNLOCKED;
                lock_run_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1          <= '0;
            s2          <= '0;
            fill        <= 2'd0;
            state       <= UNLOCKED;
            lock_run    <= '0;
            phase_idx   <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            round_tick  <= 1'b0;
            round_cnt   <= '0;
            err_onehot  <= 1'b0;
            err_seq     <= 1'b0;
        end else begin
            s1          <= phase_in;
            s2          <= s1;
            fill        <= fill_done_c ? fill : fill + 2'd1;
            state       <= state_n;
            lock_run    <= lock_run_n;
            phase_valid <= oh_c;
            locked      <= (state_n == LOCKED);
            round_tick  <= tick_c;
            if (oh_c) begin
                phase_idx <= idx_c;
            end
            if (enter_c) begin
                round_cnt <= '0;
            end else if (tick_c) begin
                round_cnt <= round_cnt + ROUND_W'(1);
            end
            // A new error outranks a clear arriving on the same cycle.
            err_onehot <= set_oh_c  | (err_onehot & ~err_clr);
            err_seq    <= set_seq_c | (err_seq    & ~err_clr);
        end
    end

`ifdef PHASE_MON_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (set_oh_c | set_seq_c) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end else if (err_clr) begin
            err_cnt_q <= 8'd0;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_phase_ring_monitor.sv
// Scoreboard bench for phase_ring_monitor: directed ring sequences, expectations queued by target cycle.
module tb_phase_ring_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] phase_in;
    logic       err_clr;
    logic [3:0] phase_idx;
    logic       phase_valid;
    logic       locked;
    logic       round_tick;
    logic [7:0] round_cnt;
    logic       err_onehot;
    logic       err_seq;
    logic [7:0] err_cnt;

    phase_ring_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .phase_in    (phase_in),
        .err_clr     (err_clr),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .locked      (locked),
        .round_tick  (round_tick),
        .round_cnt   (round_cnt),
        .err_onehot  (err_onehot),
        .err_seq     (err_seq),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tgt;
        int idx;
        int valid;
        int lck;
        int tick;
        int rcnt;
        int eoh;
        int eseq;
        int ecnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    bit   pend_clr = 1'b0;
    int   sat_cnt  = 0;

    function automatic exp_t mk(input int idx, valid, lck, tick, rcnt, eoh, eseq);
        exp_t e;
        e.tgt = 0; e.idx = idx; e.valid = valid; e.lck = lck; e.tick = tick;
        e.rcnt = rcnt; e.eoh = eoh; e.eseq = eseq; e.ecnt = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    // Monitor: compare every expectation whose target cycle has arrived.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                e = q.pop_front();
                if (e.tgt < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_check: target cycle %0d, now %0d", e.tgt, cyc);
                end else begin
                    chk("phase_idx",   int'(phase_idx),   e.idx);
                    chk("phase_valid", int'(phase_valid), e.valid);
                    chk("locked",      int'(locked),      e.lck);
                    chk("round_tick",  int'(round_tick),  e.tick);
                    chk("round_cnt",   int'(round_cnt),   e.rcnt);
                    chk("err_onehot",  int'(err_onehot),  e.eoh);
                    chk("err_seq",     int'(err_seq),     e.eseq);
                    chk("err_cnt",     int'(err_cnt),     e.ecnt);
                end
            end
        end
    end

    // One ring sample; clr asserts err_clr on the cycle this sample is evaluated.
    task automatic step(input logic [8:0] p, input bit clr, input bit err_set, input exp_t e);
        @(posedge clk);
        #1;
        phase_in = p;
        err_clr  = pend_clr;
        pend_clr = clr;
        if (err_set) sat_cnt = (sat_cnt >= 255) ? 255 : sat_cnt + 1;
        else if (clr) sat_cnt = 0;
        e.tgt = cyc + 2;
`ifdef PHASE_MON_ERRCNT_EN
        e.ecnt = sat_cnt;
`else
        e.ecnt = 0;
`endif
        q.push_back(e);
    endtask

    // Legal ring samples k0..k1 (phase k%9); lock completes at sample lk.
    task automatic ring_seg(input int k0, k1, lk, rpre, eoh, eseq, input bit clr_first);
        logic [8:0] p;
        exp_t       e;
        for (int k = k0; k <= k1; k++) begin
            p = 9'(1) << (k % 9);
            e = mk(k % 9, 1, int'(k >= lk), int'(k > lk && (k % 9) == 0),
                   (k < lk) ? rpre : ((k / 9 - lk / 9) % 256), eoh, eseq);
            step(p, clr_first && (k == k0), 1'b0, e);
        end
    endtask

    task automatic expect_zero_now();
        exp_t e;
        e = mk(0, 0, 0, 0, 0, 0, 0);
        e.tgt = cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset    = 1'b1;
        phase_in = 9'h000;
        err_clr  = 1'b0;
        pend_clr = 1'b0;
        sat_cnt  = 0;
        expect_zero_now();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        phase_in = 9'h000;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_zero_now();
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Acquire lock from 9'h001 and run past 20 completed rounds.
        ring_seg(0, 184, 3, 0, 0, 0, 1'b0);

        // Non-one-hot glitch while locked, then re-lock.
        step(9'h003, 1'b0, 1'b1, mk(4, 0, 0, 0, 20, 1, 0));
        ring_seg(186, 200, 189, 20, 1, 0, 1'b0);

        // Skipped phase 2 -> 4 while locked; clear on the same cycle loses to the new error.
        step(9'h010, 1'b1, 1'b1, mk(4, 1, 0, 0, 1, 0, 1));
        ring_seg(203, 209, 205, 1, 0, 1, 1'b0);
        ring_seg(210, 215, 205, 1, 0, 0, 1'b1);

        // Stalled ring while locked, with a simultaneous clear; then clear alone.
        step(9'h100, 1'b1, 1'b1, mk(8, 1, 0, 0, 1, 0, 1));
        ring_seg(216, 230, 218, 1, 0, 0, 1'b1);
        drain();

        // Asynchronous reset mid-round, then lock must be re-acquired.
        apply_reset();
        ring_seg(0, 12, 3, 0, 0, 0, 1'b0);

        // All-zero samples: first from LOCKED, then enough to saturate the error count.
        for (int i = 0; i < 301; i++) begin
            step(9'h000, 1'b0, 1'b1, mk(3, 0, 0, 0, 1, 1, 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
